// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin arbiter sharing one FIFO write port among producers
//
// Purpose: grants one producer at a time for a burst of up to MAX_BURST beats,
// forwards its beats to the FIFO write side and stalls while the FIFO is full.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_data  per-producer beat offer (req_data word k at [k*DATA_WIDTH +: DATA_WIDTH])
//   req_ready           per-producer accept, combinational, only for the granted producer
//   fifo_full           FIFO full flag (same cycle)
//   fifo_write_enable   write strobe, asserted on each accepted beat
//   fifo_data_in        granted producer's beat split into PAR_WRITE words
//   busy, grant_id      grant active / index of granted producer
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_WRITE  = 1,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [DATA_WIDTH*PAR_WRITE-1:0]   req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              fifo_full,
  output logic                              fifo_write_enable,
  output logic [DATA_WIDTH-1:0]             fifo_data_in [PAR_WRITE],
  output logic                              busy,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   burst_cnt;

  logic            in_grant;
  logic            beat;
  logic            pick_valid;
  logic [IW-1:0]   pick_id;
  logic [IW:0]     scan_idx;
  logic [IW-1:0]   next_ptr;

  assign in_grant = (state == GRANT);
  assign busy     = in_grant;

  // Reset gates the strobe so an interrupted burst never writes on the reset cycle.
  assign beat              = in_grant && !rst && !fifo_full && req_valid[grant_id];
  assign fifo_write_enable = beat;

  always_comb begin
    req_ready = '0;
    if (in_grant && !rst && !fifo_full) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < PAR_WRITE; k++) begin
      fifo_data_in[k] = in_grant ? req_data[grant_id][k*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  // Scan from the far end back toward rr_ptr so the nearest valid index wins last.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = {1'b0, rr_ptr} + (IW+1)'(i);
      if (scan_idx >= (IW+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (IW+1)'(NUM_REQ);
      end
      if (req_valid[scan_idx[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = scan_idx[IW-1:0];
      end
    end
  end

  assign next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id  <= pick_id;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!req_valid[grant_id]) begin
            // Producer withdrew: burst over, no beat this cycle.
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else if (beat) begin
            if (burst_cnt == CW'(MAX_BURST - 1)) begin
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [7:0]  rd [N];
  logic [N-1:0] req_ready;
  logic        fifo_full = 1'b0;
  logic        we;
  logic [7:0]  fdi [1];
  logic        busy;
  logic [1:0]  grant_id;

  logic [N-1:0] valid2 = '0;
  logic [15:0] rd2 [N];
  logic [N-1:0] rdy2;
  logic        we2;
  logic [7:0]  fdi2 [2];
  logic        busy2;
  logic [1:0]  gid2;

  fifo_write_arbiter #(.DATA_WIDTH(8), .PAR_WRITE(1), .NUM_REQ(N), .MAX_BURST(MB)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(rd), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_write_enable(we), .fifo_data_in(fdi),
    .busy(busy), .grant_id(grant_id));

  fifo_write_arbiter #(.DATA_WIDTH(8), .PAR_WRITE(2), .NUM_REQ(N), .MAX_BURST(MB)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(valid2), .req_data(rd2), .req_ready(rdy2),
    .fifo_full(1'b0), .fifo_write_enable(we2), .fifo_data_in(fdi2),
    .busy(busy2), .grant_id(gid2));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Producer beat queues and start cycles
  logic [7:0] q [N][$];
  int start_cyc [N];
  int cyc = 0;
  int rst_at = -1;
  int full_lo = -1, full_hi = -2, full_pct = 0;
  bit drop_en = 0;

  // Reference model: who owns the port, beats taken, where the scan resumes
  bit m_busy = 0;
  int m_owner = 0, m_cnt = 0, m_ptr = 0;

  logic [7:0] log_d [$];
  int log_c [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
  endtask

  task automatic new_test();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      start_cyc[i] = 0;
    end
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0; rst_at = -1; full_lo = -1; full_hi = -2; full_pct = 0; drop_en = 0;
    log_d.delete(); log_c.delete();
  endtask

  task automatic step();
    logic [N-1:0] vmask;
    logic [N-1:0] exp_rdy;
    bit exp_beat;
    bit found;
    int idx;
    @(negedge clk);
    rst = (cyc == rst_at);
    vmask = '0;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0 && cyc >= start_cyc[i] && !(drop_en && $urandom_range(0, 9) == 0))
        vmask[i] = 1'b1;
      rd[i] = (q[i].size() > 0) ? q[i][0] : 8'($urandom);
    end
    req_valid = vmask;
    fifo_full = (cyc >= full_lo && cyc <= full_hi) ||
                (full_pct > 0 && $urandom_range(0, 99) < full_pct);
    #1;
    exp_rdy = '0;
    exp_beat = 0;
    if (!rst && m_busy) begin
      if (!fifo_full) exp_rdy[m_owner] = 1'b1;
      exp_beat = vmask[m_owner] && !fifo_full;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("write_enable", 32'(we), 32'(exp_beat));
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_busy) chk("grant_id", 32'(grant_id), m_owner);
    if (exp_beat) chk("data", 32'(fdi[0]), 32'(q[m_owner][0]));
    if (we) begin
      log_d.push_back(fdi[0]);
      log_c.push_back(cyc);
    end
    // Advance the model to the state after the coming edge
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && vmask[idx]) begin
          found = 1; m_owner = idx; m_cnt = 0; m_busy = 1;
        end
      end
    end else if (!vmask[m_owner]) begin
      m_busy = 0; m_ptr = (m_owner + 1) % N;
    end else if (exp_beat) begin
      void'(q[m_owner].pop_front());
      m_cnt++;
      if (m_cnt == MB) begin
        m_busy = 0; m_ptr = (m_owner + 1) % N;
      end
    end
    cyc++;
  endtask

  task automatic run_until_done(input int limit);
    bit done;
    done = 0;
    for (int n = 0; n < limit && !done; n++) begin
      step();
      done = !m_busy;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) done = 0;
    end
    if (!done) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic check_log(input string tag, input logic [7:0] ed [$], input int ec [$]);
    chk({tag, "_count"}, log_d.size(), ed.size());
    for (int i = 0; i < ed.size() && i < log_d.size(); i++)
      chk({tag, "_data"}, 32'(log_d[i]), 32'(ed[i]));
    for (int i = 0; i < ec.size() && i < log_c.size(); i++)
      chk({tag, "_cycle"}, log_c[i], ec[i]);
  endtask

  initial begin
    logic [7:0] ed [$];
    int ec [$];
    int none [$];
    for (int i = 0; i < N; i++) begin
      rd[i] = '0;
      rd2[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    @(negedge clk);
    rst = 1'b0;

    // Two-word beat split on the PAR_WRITE=2 instance
    valid2 = 4'b0001;
    rd2[0] = 16'hBEEF;
    #1;
    chk("par2_idle_busy", 32'(busy2), 0);
    @(negedge clk);
    #1;
    chk("par2_we", 32'(we2), 1);
    chk("par2_word0", 32'(fdi2[0]), 32'h EF);
    chk("par2_word1", 32'(fdi2[1]), 32'h BE);
    valid2 = '0;

    // Single producer, 6 beats: 4-beat burst, idle cycle, regrant
    new_test();
    for (int j = 0; j < 6; j++) q[0].push_back(8'hA1 + 8'(j));
    run_until_done(40);
    ed = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    ec = '{1, 2, 3, 4, 6, 7};
    check_log("single", ed, ec);

    // All four producers, 4 beats each
    new_test();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 4; j++) q[i].push_back(8'(16 * i + j));
    run_until_done(60);
    ed.delete(); ec.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 4; j++) begin
        ed.push_back(8'(16 * i + j));
        ec.push_back(5 * i + 1 + j);
      end
    check_log("all4", ed, ec);

    // FIFO full stall after producer 2's second beat
    new_test();
    for (int j = 0; j < 4; j++) q[2].push_back(8'h20 + 8'(j));
    full_lo = 3; full_hi = 5;
    run_until_done(40);
    ed = '{8'h20, 8'h21, 8'h22, 8'h23};
    ec = '{1, 2, 6, 7};
    check_log("stall", ed, ec);

    // Producer 1 withdraws after one beat; producer 3 served next
    new_test();
    q[1].push_back(8'h31);
    q[3].push_back(8'h33);
    run_until_done(40);
    ed = '{8'h31, 8'h33};
    ec = '{1, 4};
    check_log("withdraw", ed, ec);

    // Reset on the third beat of a burst; pointer restarts at 0
    new_test();
    for (int j = 0; j < 6; j++) q[2].push_back(8'h21 + 8'(j));
    q[1].push_back(8'h11);
    start_cyc[1] = 3;
    rst_at = 3;
    run_until_done(60);
    ed = '{8'h21, 8'h22, 8'h11, 8'h23, 8'h24, 8'h25, 8'h26};
    ec = '{1, 2, 5};
    check_log("midrst", ed, ec);

    // Randomized traffic against the model, pointer carried across rounds
    new_test();
    full_pct = 25;
    drop_en = 1;
    for (int r = 0; r < 30; r++) begin
      cyc = 0;
      for (int i = 0; i < N; i++) begin
        start_cyc[i] = $urandom_range(0, 5);
        for (int j = 0; j < $urandom_range(0, 7); j++) q[i].push_back(8'($urandom));
      end
      run_until_done(400);
    end
    none.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
